// File: rtl/median_stream_ctrl_pkg.sv
// Shared types and codes for the 3x3 median streaming controller.
// Holds the FSM encoding, border policy codes and a border-test helper.
package median_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam int BORDER_PASS = 0;
  localparam int BORDER_ZERO = 1;

  localparam int PIX_W = 8;
  typedef logic [PIX_W-1:0] pix_t;

  // True when (row, col) lies on the outer ring of an h x w image.
  function automatic logic is_border(input int unsigned row, input int unsigned col,
                                     input int unsigned h, input int unsigned w);
    return (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
  endfunction

endpackage

// File: rtl/median3x3.sv
// Combinational median of nine 8-bit pixels.
// Each input is ranked with ties broken by position; the rank-4 element is the median.
module median3x3
  import median_stream_ctrl_pkg::*;
(
  input  logic [8:0][PIX_W-1:0] pix_i,
  output pix_t                  med_o
);

  logic [8:0][PIX_W-1:0] pick;

  for (genvar gi = 0; gi < 9; gi++) begin : g_rank
    logic [3:0] rank;

    always_comb begin
      rank = '0;
      for (int j = 0; j < 9; j++) begin
        if ((pix_i[j] < pix_i[gi]) || ((pix_i[j] == pix_i[gi]) && (j < gi))) begin
          rank = rank + 4'd1;
        end
      end
    end

    assign pick[gi] = (rank == 4'd4) ? pix_i[gi] : '0;
  end

  always_comb begin
    med_o = '0;
    for (int i = 0; i < 9; i++) begin
      med_o = med_o | pick[i];
    end
  end

endmodule

// File: rtl/median_stream_ctrl_line_buffer.sv
// One image line of pixel storage with a registered read port.
// The caller supplies the write column and prefetches the next column to read.
module median_stream_ctrl_line_buffer
  import median_stream_ctrl_pkg::*;
#(
  parameter int DEPTH = 320,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          shift_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  input  pix_t          data_i,
  output pix_t          data_o
);

  pix_t mem_q [DEPTH];
  pix_t rd_q;

  // Read every cycle so a stalled stream keeps presenting the same column.
  always_ff @(posedge clk) begin
    if (shift_i) begin
      mem_q[wr_addr_i] <= data_i;
    end
    rd_q <= mem_q[rd_addr_i];
  end

  assign data_o = rd_q;

endmodule

// File: rtl/median_stream_ctrl.sv
// Raster-stream 3x3 median controller: line buffers, window, border policy,
// end-of-frame flush and a single-stage valid/ready output register.
module median_stream_ctrl
  import median_stream_ctrl_pkg::*;
#(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int BORDER_MODE = BORDER_PASS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_sof,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_sof,
  output logic       m_eol,
  output logic       busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] in_col_q, in_col_d;
  logic [RW-1:0] in_row_q, in_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic          ena_q;
  logic          m_valid_q, m_valid_d;
  pix_t          m_data_q, m_data_d;
  logic          m_sof_q, m_sof_d;
  logic          m_eol_q, m_eol_d;

  logic          step, xfer, sof_x, flush_step, shift, emit;
  logic [CW-1:0] cur_col;
  pix_t          in_pix, centre, med, out_pix;
  logic          border;

  logic [2:0][PIX_W-1:0] lb_tap;
  logic [2:0][PIX_W-1:0] win_l_q, win_m_q;
  logic [8:0][PIX_W-1:0] med_in;

  function automatic logic [CW-1:0] col_inc(input logic [CW-1:0] c);
    return (c == COL_LAST) ? '0 : c + CW'(1);
  endfunction

  // ena_q holds s_ready low while reset is applied and for the first cycle after.
  assign step       = !m_valid_q || m_ready;
  assign s_ready    = ena_q && step && (state_q != ST_FLUSH);
  assign xfer       = s_valid && s_ready;
  assign sof_x      = xfer && s_sof;
  assign flush_step = step && (state_q == ST_FLUSH);
  assign shift      = (xfer && (s_sof || (state_q != ST_IDLE))) || flush_step;
  assign emit       = (xfer && !s_sof && (state_q == ST_RUN)) || flush_step;
  assign cur_col    = sof_x ? '0 : in_col_q;
  assign in_pix     = (state_q == ST_FLUSH) ? '0 : s_data;

  // lb_tap[0] is the live pixel, [1] the line above it, [2] two lines above.
  assign lb_tap[0] = in_pix;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lb
    median_stream_ctrl_line_buffer #(
      .DEPTH (IMG_W)
    ) u_lb (
      .clk       (clk),
      .shift_i   (shift),
      .wr_addr_i (cur_col),
      .rd_addr_i (in_col_d),
      .data_i    (lb_tap[gi]),
      .data_o    (lb_tap[gi+1])
    );
  end

  // Window rows are indexed top (0) to bottom (2); the right column is combinational.
  always_ff @(posedge clk) begin
    if (shift) begin
      win_l_q <= win_m_q;
      for (int r = 0; r < 3; r++) begin
        win_m_q[r] <= lb_tap[2-r];
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_win
    assign med_in[gi*3+0] = win_l_q[gi];
    assign med_in[gi*3+1] = win_m_q[gi];
    assign med_in[gi*3+2] = lb_tap[2-gi];
  end

  median3x3 u_median (
    .pix_i (med_in),
    .med_o (med)
  );

  assign centre  = win_m_q[1];
  assign border  = is_border(32'(out_row_q), 32'(out_col_q), IMG_H, IMG_W);
  assign out_pix = !border ? med : ((BORDER_MODE == BORDER_ZERO) ? '0 : centre);

  always_comb begin
    state_d   = state_q;
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    if (sof_x) begin
      state_d   = ST_FILL;
      in_col_d  = CW'(1);
      in_row_d  = '0;
      out_col_d = '0;
      out_row_d = '0;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          if (xfer) begin
            if ((in_row_q == RW'(1)) && (in_col_q == '0)) state_d = ST_RUN;
            in_col_d = col_inc(in_col_q);
            if (in_col_q == COL_LAST) in_row_d = in_row_q + RW'(1);
          end
        end
        ST_RUN: begin
          if (xfer) begin
            if ((in_row_q == ROW_LAST) && (in_col_q == COL_LAST)) begin
              state_d  = ST_FLUSH;
              in_col_d = '0;
              in_row_d = '0;
            end else begin
              in_col_d = col_inc(in_col_q);
              if (in_col_q == COL_LAST) in_row_d = in_row_q + RW'(1);
            end
          end
        end
        ST_FLUSH: begin
          // Virtual pixels only need a column address; the row stays parked.
          if (flush_step) in_col_d = col_inc(in_col_q);
        end
        default: ;
      endcase
      if (emit) begin
        out_col_d = col_inc(out_col_q);
        if (out_col_q == COL_LAST) begin
          out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + RW'(1);
        end
        if ((state_q == ST_FLUSH) && (out_row_q == ROW_LAST) && (out_col_q == COL_LAST)) begin
          state_d  = ST_IDLE;
          in_col_d = '0;
          in_row_d = '0;
        end
      end
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_sof_d   = m_sof_q;
    m_eol_d   = m_eol_q;
    if (step) begin
      m_valid_d = emit;
      m_sof_d   = emit && (out_row_q == '0) && (out_col_q == '0);
      m_eol_d   = emit && (out_col_q == COL_LAST);
      if (emit) m_data_d = out_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      ena_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      ena_q     <= 1'b1;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_sof_q   <= m_sof_d;
      m_eol_q   <= m_eol_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_sof   = m_sof_q;
  assign m_eol   = m_eol_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_median_stream_ctrl.sv
// Bench for median_stream_ctrl on an 8x6 image: one instance per border mode,
// checked against a frame-level median model through an expected-output queue.
module tb_median_stream_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  typedef logic [7:0] frame_t [N];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_sof = 1'b0;
  logic       m_ready = 1'b0;

  logic       s_ready0, m_valid0, m_sof0, m_eol0, busy0;
  logic       s_ready1, m_valid1, m_sof1, m_eol1, busy1;
  logic [7:0] m_data0, m_data1;

  always #5 clk = ~clk;

  median_stream_ctrl #(.IMG_W(W), .IMG_H(H), .BORDER_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .s_sof(s_sof), .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
    .m_sof(m_sof0), .m_eol(m_eol0), .busy(busy0)
  );

  median_stream_ctrl #(.IMG_W(W), .IMG_H(H), .BORDER_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .s_sof(s_sof), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
    .m_sof(m_sof1), .m_eol(m_eol1), .busy(busy1)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_pct = 100;
  int ready_pct = 100;
  int acc_cyc = 0;
  int out_cyc = 0;
  logic lat_arm = 1'b0;
  logic stall_prev = 1'b0;
  logic [7:0] stall_d0 = 8'h00;
  logic [7:0] stall_d1 = 8'h00;

  logic [7:0] exp0_q [$];
  logic [7:0] exp1_q [$];
  logic       exp_sof_q [$];
  logic       exp_eol_q [$];

  frame_t f_a, f_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] med9(input logic [7:0] v [9]);
    logic [7:0] a [9];
    logic [7:0] t;
    a = v;
    for (int i = 1; i < 9; i++)
      for (int j = i; j > 0; j--)
        if (a[j] < a[j-1]) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
    return a[4];
  endfunction

  function automatic logic [7:0] golden(input frame_t f, input int r, input int c, input int mode);
    logic [7:0] v [9];
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1)
      return (mode == 1) ? 8'h00 : f[r*W+c];
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        v[(dr+1)*3 + dc + 1] = f[(r+dr)*W + c + dc];
    return med9(v);
  endfunction

  task automatic expect_frame(input frame_t f, input int nout);
    for (int i = 0; i < nout; i++) begin
      exp0_q.push_back(golden(f, i / W, i % W, 0));
      exp1_q.push_back(golden(f, i / W, i % W, 1));
      exp_sof_q.push_back(i == 0);
      exp_eol_q.push_back((i % W) == W - 1);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, input logic sof);
    int guard;
    logic done;
    guard = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      s_data = d;
      s_sof = sof;
      s_valid = ($urandom_range(0, 99) < valid_pct);
      #4;
      if (s_valid && s_ready0) done = 1'b1;
      guard++;
      if (!done && guard > 500) begin
        total++; bad++;
        $display("FAIL send_timeout: got no s_ready in %0d cycles want accept", guard);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int n, input logic sof_first);
    for (int i = 0; i < n; i++) begin
      send(f[i], sof_first && (i == 0));
      if (i == 0) acc_cyc = cyc;
    end
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((exp0_q.size() != 0 || busy0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check({name, "_left"}, exp0_q.size(), 0);
    check({name, "_busy"}, busy0, 1'b0);
  endtask

  initial forever begin
    @(negedge clk);
    m_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      check("rst_m_valid", m_valid0, 1'b0);
      check("rst_m_data", m_data0, 8'h00);
      check("rst_m_sof", m_sof0, 1'b0);
      check("rst_m_eol", m_eol0, 1'b0);
      check("rst_busy", busy0, 1'b0);
      check("rst_s_ready", s_ready0, 1'b0);
      check("rst_m_valid1", m_valid1, 1'b0);
      stall_prev = 1'b0;
    end else begin
      if (lat_arm && m_valid0) begin
        out_cyc = cyc;
        lat_arm = 1'b0;
      end
      if (stall_prev) begin
        check("hold_valid", m_valid0, 1'b1);
        check("hold_data0", m_data0, stall_d0);
        check("hold_data1", m_data1, stall_d1);
      end
      if (m_valid0 && m_ready) begin
        if (exp0_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_output: got data %0h with no expected output", m_data0);
        end else begin
          check("data_mode0", m_data0, exp0_q.pop_front());
          check("data_mode1", m_data1, exp1_q.pop_front());
          check("valid_mode1", m_valid1, 1'b1);
          check("m_sof", m_sof0, exp_sof_q[0]);
          check("m_eol", m_eol0, exp_eol_q[0]);
          check("m_sof1", m_sof1, exp_sof_q.pop_front());
          check("m_eol1", m_eol1, exp_eol_q.pop_front());
        end
      end
      stall_prev = m_valid0 && !m_ready;
      stall_d0 = m_data0;
      stall_d1 = m_data1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] pv [9];

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed pins on the model.
    for (int i = 0; i < 9; i++) pv[i] = 8'(((i * 7) % 9) + 1);
    check("pin_med_perm", med9(pv), 8'd5);
    for (int i = 0; i < 9; i++) pv[i] = (i < 4) ? 8'd0 : 8'd255;
    check("pin_med_dup", med9(pv), 8'd255);
    for (int i = 0; i < N; i++) f_a[i] = 8'(i);
    check("pin_ramp_int", golden(f_a, 2, 3, 1), 8'd19);
    check("pin_ramp_top0", golden(f_a, 0, 3, 1), 8'd0);
    check("pin_ramp_corner", golden(f_a, 5, 7, 0), 8'd47);
    for (int i = 0; i < N; i++) f_b[i] = 8'h10;
    f_b[2*W+3] = 8'hFF;
    check("pin_impulse", golden(f_b, 2, 3, 0), 8'h10);

    // Flat field with latency measurement.
    valid_pct = 100; ready_pct = 100;
    for (int i = 0; i < N; i++) f_a[i] = 8'h40;
    expect_frame(f_a, N);
    lat_arm = 1'b1;
    send_frame(f_a, N, 1'b1);
    idle_in();
    drain("flat");
    check("latency", out_cyc - acc_cyc, 10);

    // Impulse in flat field.
    expect_frame(f_b, N);
    send_frame(f_b, N, 1'b1);
    idle_in();
    drain("impulse");

    // Ramp.
    for (int i = 0; i < N; i++) f_a[i] = 8'(i);
    expect_frame(f_a, N);
    send_frame(f_a, N, 1'b1);
    idle_in();
    drain("ramp");

    // Random data with random flow control on both sides.
    valid_pct = 50; ready_pct = 50;
    for (int i = 0; i < N; i++) f_a[i] = 8'($urandom_range(0, 255));
    expect_frame(f_a, N);
    send_frame(f_a, N, 1'b1);
    idle_in();
    drain("random");

    // Resync: new s_sof on the 21st pixel of a frame.
    valid_pct = 70; ready_pct = 70;
    for (int i = 0; i < N; i++) f_a[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < N; i++) f_b[i] = 8'($urandom_range(0, 255));
    expect_frame(f_a, 20 - (W + 1));
    send_frame(f_a, 20, 1'b1);
    expect_frame(f_b, N);
    send_frame(f_b, N, 1'b1);
    idle_in();
    drain("resync");

    // Asynchronous reset in the middle of RUN.
    valid_pct = 100; ready_pct = 100;
    for (int i = 0; i < N; i++) f_a[i] = 8'($urandom_range(0, 255));
    expect_frame(f_a, N);
    send_frame(f_a, 25, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp0_q.delete(); exp1_q.delete(); exp_sof_q.delete(); exp_eol_q.delete();
    #1;
    check("async_m_valid", m_valid0, 1'b0);
    check("async_m_data", m_data0, 8'h00);
    check("async_busy", busy0, 1'b0);
    check("async_s_ready", s_ready0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) send(8'(8'hA0 + i), 1'b0);
    idle_in();
    repeat (12) @(negedge clk);
    check("discard_busy", busy0, 1'b0);
    check("discard_valid", m_valid0, 1'b0);
    for (int i = 0; i < N; i++) f_b[i] = 8'(N - 1 - i);
    expect_frame(f_b, N);
    send_frame(f_b, N, 1'b1);
    idle_in();
    drain("after_reset");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
